// File: rtl/video_pkg.sv
// Shared video definitions: capture FSM states, default frame geometry and
// the pixel write payload handed to the frame memory.
package video_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned CNT_W        = 10;
    localparam int unsigned BYTE_W       = 8;
    localparam int unsigned PIX_W        = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_e;

    // One frame-memory write: coordinates plus RGB565 data
    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic [PIX_W-1:0] data;
    } pix_wr_t;

endpackage

// File: rtl/pixel_pair_assembler.sv
// Pairs camera bytes into 16-bit pixels.
//   enable        : bytes are accepted only while high
//   clear         : drop byte phase (line end / outside capture)
//   byte_en, href : qualify data as a valid active byte
//   pixel_c       : current first byte combined with data, ordered by HI_BYTE_FIRST
//   pixel_valid_c : high in the cycle the second byte of a pair is presented
module pixel_pair_assembler
    import video_pkg::*;
#(
    parameter bit HI_BYTE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              clear,
    input  logic              byte_en,
    input  logic              href,
    input  logic [BYTE_W-1:0] data,
    output logic [PIX_W-1:0]  pixel_c,
    output logic              pixel_valid_c
);

    logic              phase;
    logic [BYTE_W-1:0] first_q;
    logic              strobe_c;

    assign strobe_c      = enable & byte_en & href;
    assign pixel_valid_c = strobe_c & phase;
    assign pixel_c       = HI_BYTE_FIRST ? {first_q, data} : {data, first_q};

    // Byte phase and first-byte latch; clear wins so a dangling odd byte is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase   <= 1'b0;
            first_q <= '0;
        end else if (clear) begin
            phase   <= 1'b0;
        end else if (strobe_c) begin
            if (!phase) first_q <= data;
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/camera_frame_writer.sv
// Camera capture front end for the shared frame memory.
//   capture_start           : request capture of the next full frame
//   cam_vsync/href/byte_en/data : synchronous camera byte stream
//   camera_request          : memory ownership, registered copy of CAPTURE
//   camera_hcount/vcount, dout_camera, mwe_camera : pixel write port
//   capture_done            : one-cycle pulse on entering DONE
//   frame_error             : sticky short-frame flag
module camera_frame_writer
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE      = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE      = V_ACTIVE_DEF,
    parameter bit          HI_BYTE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_start,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic              cam_byte_en,
    input  logic [BYTE_W-1:0] cam_data,
    output logic              camera_request,
    output logic [CNT_W-1:0]  camera_hcount,
    output logic [CNT_W-1:0]  camera_vcount,
    output logic [PIX_W-1:0]  dout_camera,
    output logic              mwe_camera,
    output logic              capture_done,
    output logic              frame_error
);

    cap_state_e       state, state_d;
    logic             vsync_q, href_q;
    logic [CNT_W-1:0] col_q, row_q, col_d, row_d;
    logic [CNT_W-1:0] row_inc_c;
    logic             vsync_fall_c, vsync_rise_c, href_fall_c;
    logic             in_capture_c, line_last_c;
    logic [PIX_W-1:0] pixel_c;
    logic             pixel_valid_c;
    pix_wr_t          wr_d;
    logic             mwe_d, done_d, err_d;

    assign vsync_fall_c = vsync_q & ~cam_vsync;
    assign vsync_rise_c = ~vsync_q & cam_vsync;
    assign href_fall_c  = href_q & ~cam_href;
    assign in_capture_c = (state == CAPTURE);
    assign row_inc_c    = row_q + CNT_W'(1);
    assign line_last_c  = (row_inc_c == CNT_W'(V_ACTIVE));

    pixel_pair_assembler #(
        .HI_BYTE_FIRST (HI_BYTE_FIRST)
    ) u_pair (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (in_capture_c),
        .clear         (~in_capture_c | href_fall_c),
        .byte_en       (cam_byte_en),
        .href          (cam_href),
        .data          (cam_data),
        .pixel_c       (pixel_c),
        .pixel_valid_c (pixel_valid_c)
    );

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    // Next-state logic; a completed last line takes precedence over a vsync rise
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (capture_start) state_d = ARM;
            ARM:     if (vsync_fall_c)  state_d = CAPTURE;
            CAPTURE: begin
                if (href_fall_c && line_last_c)
                    state_d = DONE;
                else if (vsync_rise_c && (row_q < CNT_W'(V_ACTIVE)))
                    state_d = DONE;
            end
            DONE:    if (capture_start) state_d = ARM;
            default: state_d = IDLE;
        endcase
    end

    // Output/datapath next values; a pixel strobe is applied before the line advance
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        mwe_d       = 1'b0;
        wr_d.hcount = camera_hcount;
        wr_d.vcount = camera_vcount;
        wr_d.data   = dout_camera;
        done_d      = (state_d == DONE) && (state != DONE);
        err_d       = frame_error;

        if (((state == IDLE) || (state == DONE)) && capture_start)
            err_d = 1'b0;
        if (in_capture_c && (state_d == DONE) && !(href_fall_c && line_last_c))
            err_d = 1'b1;

        if (!in_capture_c) begin
            col_d = '0;
            row_d = '0;
        end else begin
            if (pixel_valid_c && (col_q < CNT_W'(H_ACTIVE))) begin
                mwe_d       = 1'b1;
                wr_d.hcount = col_q;
                wr_d.vcount = row_q;
                wr_d.data   = pixel_c;
                col_d       = col_q + CNT_W'(1);
            end
            if (href_fall_c) begin
                col_d = '0;
                row_d = row_inc_c;
            end
        end
    end

    // Registered outputs, counters and edge-detect history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vsync_q        <= 1'b0;
            href_q         <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            camera_request <= 1'b0;
            camera_hcount  <= '0;
            camera_vcount  <= '0;
            dout_camera    <= '0;
            mwe_camera     <= 1'b0;
            capture_done   <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            vsync_q        <= cam_vsync;
            href_q         <= cam_href;
            col_q          <= col_d;
            row_q          <= row_d;
            camera_request <= in_capture_c;
            camera_hcount  <= wr_d.hcount;
            camera_vcount  <= wr_d.vcount;
            dout_camera    <= wr_d.data;
            mwe_camera     <= mwe_d;
            capture_done   <= done_d;
            frame_error    <= err_d;
        end
    end

endmodule

// File: tb/tb_camera_frame_writer.sv
module tb_camera_frame_writer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        capture_start;
    logic        cam_vsync;
    logic        cam_href;
    logic        cam_byte_en;
    logic [7:0]  cam_data;

    logic        req, mwe, done, err;
    logic [9:0]  hc, vc;
    logic [15:0] dout;
    logic        req2, mwe2, done2, err2;
    logic [9:0]  hc2, vc2;
    logic [15:0] dout2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0]  h;
        logic [9:0]  v;
        logic [15:0] d;
        logic [15:0] d2;
    } wr_t;

    wr_t wr_q[$];
    int  req_cycles = 0;
    int  done_cnt   = 0;
    int  bad_wr     = 0;

    logic [15:0] exp_d  [8] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDE00,
                               16'h0102, 16'h0304, 16'h0506, 16'h0708};
    logic [15:0] exp_d2 [8] = '{16'h3412, 16'h7856, 16'hBC9A, 16'h00DE,
                               16'h0201, 16'h0403, 16'h0605, 16'h0807};

    always #5 clk = ~clk;

    camera_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .HI_BYTE_FIRST(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .capture_start(capture_start),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte_en(cam_byte_en),
        .cam_data(cam_data), .camera_request(req), .camera_hcount(hc),
        .camera_vcount(vc), .dout_camera(dout), .mwe_camera(mwe),
        .capture_done(done), .frame_error(err)
    );

    camera_frame_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .HI_BYTE_FIRST(1'b0)) dut2 (
        .clk(clk), .reset_n(reset_n), .capture_start(capture_start),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_byte_en(cam_byte_en),
        .cam_data(cam_data), .camera_request(req2), .camera_hcount(hc2),
        .camera_vcount(vc2), .dout_camera(dout2), .mwe_camera(mwe2),
        .capture_done(done2), .frame_error(err2)
    );

    // Write/ownership monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (reset_n) begin
            if (mwe) wr_q.push_back('{h: hc, v: vc, d: dout, d2: dout2});
            if (req) req_cycles++;
            if (done) done_cnt++;
            if (mwe && !req) bad_wr++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_data    = b;
        cam_byte_en = 1'b1;
        tick();
        cam_byte_en = 1'b0;
        tick();
    endtask

    // Line of n bytes: first, first+step, ... ; ends on the cycle href_fall is sampled
    task automatic send_line(input int n, input logic [7:0] first, input logic [7:0] step);
        logic [7:0] b;
        b = first;
        cam_href = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            send_byte(b);
            b = b + step;
        end
        cam_href = 1'b0;
        tick();
    endtask

    task automatic frame_start();
        cam_vsync = 1'b1;
        tick();
        tick();
        cam_vsync = 1'b0;
        tick();
        tick();
    endtask

    task automatic pulse_start();
        capture_start = 1'b1;
        tick();
        capture_start = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        capture_start = 1'b0;
        cam_vsync = 1'b0;
        cam_href = 1'b0;
        cam_byte_en = 1'b0;
        cam_data = 8'h00;

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            capture_start = 1'($urandom);
            cam_vsync     = 1'($urandom);
            cam_href      = 1'($urandom);
            cam_byte_en   = 1'($urandom);
            cam_data      = 8'($urandom);
            tick();
            check("reset_outputs", {req, hc, vc, dout, mwe, done, err}, 32'h0);
        end
        capture_start = 1'b0;
        cam_vsync = 1'b1;
        cam_href = 1'b0;
        cam_byte_en = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        // Two frames with no capture_start
        for (int f = 0; f < 2; f++) begin
            frame_start();
            send_line(8, 8'h12, 8'h22);
            send_line(8, 8'h01, 8'h01);
        end
        tick();
        check("idle_req_cycles", 32'(req_cycles), 32'd0);
        check("idle_writes", 32'(wr_q.size()), 32'd0);

        // Full small frame: long line with odd byte, then normal line
        cam_vsync = 1'b1;
        done_cnt = 0;
        pulse_start();
        tick();
        check("arm_req_low", 32'(req), 32'd0);
        cam_vsync = 1'b0;
        tick();
        tick();
        check("capture_req_high", 32'(req), 32'd1);
        send_line(13, 8'h12, 8'h22);
        tick();
        send_line(8, 8'h01, 8'h01);
        check("done_pulse", {30'd0, done, req}, 32'h3);
        tick();
        check("done_clear_req_low", {30'd0, done, req}, 32'h0);
        check("frame_writes", 32'(wr_q.size()), 32'd8);
        if (wr_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                check($sformatf("wr%0d_hc", i), 32'(wr_q[i].h), 32'(i % 4));
                check($sformatf("wr%0d_vc", i), 32'(wr_q[i].v), 32'(i / 4));
                check($sformatf("wr%0d_hi", i), 32'(wr_q[i].d), 32'(exp_d[i]));
                check($sformatf("wr%0d_lo", i), 32'(wr_q[i].d2), 32'(exp_d2[i]));
            end
        end
        check("done_count", 32'(done_cnt), 32'd1);
        check("no_wr_without_req", 32'(bad_wr), 32'd0);
        check("no_err_full", 32'(err), 32'd0);
        cam_vsync = 1'b1;
        tick();
        tick();
        check("done_holds", {30'd0, req, done}, 32'h0);

        // Short frame with byte-order check
        wr_q.delete();
        done_cnt = 0;
        pulse_start();
        frame_start();
        send_line(2, 8'hAB, 8'h22);
        check("short_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) begin
            check("order_hi_first", 32'(wr_q[0].d), 32'h0000ABCD);
            check("order_lo_first", 32'(wr_q[0].d2), 32'h0000CDAB);
            check("short_coord", {12'd0, wr_q[0].h, wr_q[0].v}, 32'h0);
        end
        tick();
        cam_vsync = 1'b1;
        tick();
        check("short_err_done", {30'd0, err, done}, 32'h3);
        tick();
        check("short_req_low", {30'd0, req, done}, 32'h0);
        check("short_err_sticky", 32'(err), 32'd1);
        pulse_start();
        check("err_cleared", 32'(err), 32'd0);

        // Reset mid-line, then recapture
        tick();
        cam_vsync = 1'b0;
        tick();
        tick();
        cam_href = 1'b1;
        tick();
        send_byte(8'h11);
        cam_data = 8'h22;
        cam_byte_en = 1'b1;
        tick();
        cam_byte_en = 1'b0;
        check("pre_reset_write", {30'd0, req, mwe}, 32'h3);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", {req, mwe, done, err, hc, vc, dout[7:0]}, 32'h0);
        tick();
        reset_n = 1'b1;
        tick();
        wr_q.delete();
        pulse_start();
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h55);
        cam_href = 1'b0;
        tick();
        check("armed_no_writes", 32'(wr_q.size()), 32'd0);
        frame_start();
        send_line(2, 8'h5A, 8'h11);
        check("recap_wr_count", 32'(wr_q.size()), 32'd1);
        if (wr_q.size() == 1) begin
            check("recap_coord", {12'd0, wr_q[0].h, wr_q[0].v}, 32'h0);
            check("recap_data", 32'(wr_q[0].d), 32'h00005A6B);
        end
        check("recap_no_bad_wr", 32'(bad_wr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
